// File: rtl/eth_mem_bridge_if.sv
// Bus bundle for eth_mem_bridge: rx beats, tx beats and the memory port.
// The master view belongs to the bridge, the slave view to its environment.
interface eth_mem_bridge_if #(
    parameter int LINE_BEATS = 4,
    parameter int ADDR_W     = 26
);
    logic [63:0]              rxq_bits;
    logic [7:0]               rxq_aux_bits;
    logic                     rxq_val;
    logic                     rxq_rdy;
    logic [63:0]              txq_bits;
    logic [7:0]               txq_aux_bits;
    logic                     txq_val;
    logic                     txq_rdy;
    logic                     mem_req_val;
    logic                     mem_req_rdy;
    logic                     mem_req_rw;
    logic [ADDR_W-1:0]        mem_req_addr;
    logic [64*LINE_BEATS-1:0] mem_req_data;
    logic                     mem_resp_val;
    logic [64*LINE_BEATS-1:0] mem_resp_data;

    modport master (
        input  rxq_bits, rxq_aux_bits, rxq_val,
        output rxq_rdy,
        output txq_bits, txq_aux_bits, txq_val,
        input  txq_rdy,
        output mem_req_val, mem_req_rw,
        output mem_req_addr, mem_req_data,
        input  mem_req_rdy,
        input  mem_resp_val, mem_resp_data
    );

    modport slave (
        output rxq_bits, rxq_aux_bits, rxq_val,
        input  rxq_rdy,
        input  txq_bits, txq_aux_bits, txq_val,
        output txq_rdy,
        input  mem_req_val, mem_req_rw,
        input  mem_req_addr, mem_req_data,
        output mem_req_rdy,
        output mem_resp_val, mem_resp_data
    );
endinterface

// File: rtl/eth_mem_bridge.sv
// Ethernet-framed memory bridge: parses load/store command frames,
// issues one line request at a time and frames the reply back out.
module eth_mem_bridge #(
    parameter int          LINE_BEATS = 4,
    parameter int          ADDR_W     = 26,
    parameter logic [15:0] ETH_TYPE   = 16'h8888,
    parameter logic [47:0] MAC_SRC    = 48'h010203040506,
    parameter logic [47:0] MAC_DST    = 48'hffffffffffff
) (
    input  logic                clk,
    input  logic                reset,
    eth_mem_bridge_if.master    bus,
    output logic [15:0]         drop_cnt
);
    localparam int OFF = $clog2(8 * LINE_BEATS);
    localparam int CW  = $clog2(LINE_BEATS + 1);
    localparam int BW  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

    typedef enum logic [2:0] {
        RX_HDR, RX_CMD, RX_DATA, RX_ISSUE, RX_DRAIN
    } rx_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_WAIT, TX_HDR1, TX_HDR2, TX_BODY
    } tx_t;

    rx_t                      r_rx;
    tx_t                      r_tx;
    logic                     r_beat1;
    logic [CW-1:0]            r_wcnt;
    logic                     r_rw;
    logic [15:0]              r_tag;
    logic [ADDR_W-1:0]        r_addr;
    logic [64*LINE_BEATS-1:0] r_line;
    logic [BW-1:0]            r_k;
    logic [15:0]              r_drop;

    logic                     w_rx_fire;
    logic                     w_tx_fire;
    logic                     w_req_fire;
    logic                     w_last;
    logic                     w_cmd_ok;
    logic                     w_more;
    logic [CW-1:0]            w_wcnt_nxt;
    logic                     w_pending;
    logic                     w_drop;
    logic [ADDR_W-1:0]        w_laddr;
    logic [63:0]              w_word;
    logic [63:0]              w_tx_bits;
    logic [7:0]               w_tx_aux;
    logic                     w_unused;

    assign w_rx_fire  = bus.rxq_val && bus.rxq_rdy;
    assign w_tx_fire  = bus.txq_val && bus.txq_rdy;
    assign w_req_fire = (r_rx == RX_ISSUE) && bus.mem_req_rdy;
    assign w_last     = bus.rxq_aux_bits[6];
    assign w_cmd_ok   = (bus.rxq_bits[15:1] == 15'd0);
    assign w_more     = r_rw && (r_wcnt < CW'(LINE_BEATS));
    assign w_wcnt_nxt = r_wcnt + (w_more ? CW'(1) : CW'(0));
    assign w_pending  = r_rw && (w_wcnt_nxt < CW'(LINE_BEATS));
    assign w_laddr    = ADDR_W'({32'd0, bus.rxq_bits[63:32]} >> OFF);
    assign w_unused   = ^{bus.rxq_aux_bits[7], bus.rxq_aux_bits[5:0]};

    // Hold off a new frame until the previous reply has fully left.
    assign bus.rxq_rdy = (r_rx != RX_ISSUE) &&
                         !((r_rx == RX_HDR) && !r_beat1 &&
                           (r_tx != TX_IDLE));

    assign bus.mem_req_val  = (r_rx == RX_ISSUE);
    assign bus.mem_req_rw   = r_rw;
    assign bus.mem_req_addr = r_addr;
    assign bus.mem_req_data = r_line;

    assign bus.txq_val = (r_tx == TX_HDR1) || (r_tx == TX_HDR2) ||
                         (r_tx == TX_BODY);
    assign bus.txq_bits     = w_tx_bits;
    assign bus.txq_aux_bits = w_tx_aux;
    assign drop_cnt         = r_drop;

    // Decide whether the beat being accepted condemns the current frame.
    always_comb begin
        w_drop = 1'b0;
        if (w_rx_fire) begin
            case (r_rx)
                RX_HDR:
                    w_drop = w_last ||
                             (r_beat1 && (bus.rxq_bits[47:32] != ETH_TYPE));
                RX_CMD:
                    w_drop = !w_cmd_ok || (bus.rxq_bits[0] && w_last);
                RX_DATA:
                    w_drop = w_last && w_pending;
                default:
                    w_drop = 1'b0;
            endcase
        end
    end

    // Receive FSM and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx    <= RX_HDR;
            r_beat1 <= 1'b0;
            r_wcnt  <= '0;
            r_rw    <= 1'b0;
            r_tag   <= '0;
            r_addr  <= '0;
            r_drop  <= '0;
        end else begin
            if (w_drop && (r_drop != 16'hffff))
                r_drop <= r_drop + 16'd1;
            if (w_rx_fire) begin
                case (r_rx)
                    RX_HDR: begin
                        if (w_drop) begin
                            r_beat1 <= 1'b0;
                            r_rx    <= w_last ? RX_HDR : RX_DRAIN;
                        end else if (!r_beat1) begin
                            r_beat1 <= 1'b1;
                        end else begin
                            r_beat1 <= 1'b0;
                            r_rx    <= RX_CMD;
                        end
                    end
                    RX_CMD: begin
                        if (w_drop) begin
                            r_rx <= w_last ? RX_HDR : RX_DRAIN;
                        end else begin
                            r_rw   <= bus.rxq_bits[0];
                            r_tag  <= bus.rxq_bits[31:16];
                            r_addr <= w_laddr;
                            r_wcnt <= '0;
                            r_rx   <= w_last ? RX_ISSUE : RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        r_wcnt <= w_wcnt_nxt;
                        if (w_last)
                            r_rx <= w_drop ? RX_HDR : RX_ISSUE;
                    end
                    RX_DRAIN: begin
                        if (w_last)
                            r_rx <= RX_HDR;
                    end
                    default: r_rx <= r_rx;
                endcase
            end
            if (w_req_fire)
                r_rx <= RX_HDR;
        end
    end

    // Line buffer: store data on the way in, load data on the way back.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_line <= '0;
        end else if ((r_tx == TX_WAIT) && bus.mem_resp_val) begin
            r_line <= bus.mem_resp_data;
        end else if ((r_rx == RX_DATA) && w_rx_fire && w_more) begin
            for (int i = 0; i < LINE_BEATS; i++)
                if (r_wcnt == CW'(i))
                    r_line[i*64 +: 64] <= bus.rxq_bits;
        end
    end

    // Transmit FSM: advances only on a sent beat once the reply is ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx <= TX_IDLE;
            r_k  <= '0;
        end else begin
            case (r_tx)
                TX_IDLE:
                    if (w_req_fire)
                        r_tx <= r_rw ? TX_HDR1 : TX_WAIT;
                TX_WAIT:
                    if (bus.mem_resp_val)
                        r_tx <= TX_HDR1;
                TX_HDR1:
                    if (w_tx_fire)
                        r_tx <= TX_HDR2;
                TX_HDR2:
                    if (w_tx_fire) begin
                        r_k  <= '0;
                        r_tx <= r_rw ? TX_IDLE : TX_BODY;
                    end
                TX_BODY:
                    if (w_tx_fire) begin
                        if (r_k == BW'(LINE_BEATS - 1))
                            r_tx <= TX_IDLE;
                        else
                            r_k <= r_k + BW'(1);
                    end
                default: r_tx <= TX_IDLE;
            endcase
        end
    end

    // Select the outgoing beat and its flags from the tx state.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < LINE_BEATS; i++)
            if (r_k == BW'(i))
                w_word = r_line[i*64 +: 64];
        w_tx_bits = '0;
        w_tx_aux  = '0;
        case (r_tx)
            TX_HDR1: begin
                w_tx_bits = {MAC_SRC[15:0], MAC_DST};
                w_tx_aux  = 8'h07;
            end
            TX_HDR2: begin
                w_tx_bits = {r_tag, ETH_TYPE, MAC_SRC[47:16]};
                w_tx_aux  = r_rw ? 8'h47 : 8'h07;
            end
            TX_BODY: begin
                w_tx_bits = w_word;
                w_tx_aux  = (r_k == BW'(LINE_BEATS - 1)) ? 8'h47 : 8'h07;
            end
            default: begin
                w_tx_bits = '0;
                w_tx_aux  = '0;
            end
        endcase
    end
endmodule
